add_sub: RTL and testbench

Single-precision (IEEE-754 binary32) floating-point adder/subtractor for the ALU unit. It computes O = A + B or O = A − B as selected by A_S, with round-to-nearest-even. The result is registered, so it presents one clock of latency. It is the add/sub leaf of the floating-point ALU datapath, alongside the multiply and divide units.

---
 rtl/fp32_pkg.sv | 41 ++++
 rtl/fp_lzc.sv | 15 +
 rtl/add_sub.sv | 131 +++++++++++++
 tb/tb_add_sub.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the floating-point ALU leaves:
// field widths, special encodings and the unpacked-operand view.
package fp32_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;
   localparam int SIG_W   = FRAC_W + 1;
   localparam int EXT_W   = SIG_W + 3;
   localparam int EXP_MAX = 2 * BIAS + 1;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
      logic             is_zero;
      logic             is_inf;
      logic             is_nan;
   } fp_unpacked_t;

   // Denormals collapse to zero here, so downstream logic only sees
   // normal significands with the hidden bit set.
   function automatic fp_unpacked_t fp_unpack(input logic [31:0] value,
                                              input logic        sign_flip);
      fp_unpacked_t     u;
      logic [FRAC_W-1:0] frac;
      frac      = value[FRAC_W-1:0];
      u.sign    = value[31] ^ sign_flip;
      u.exp     = value[30:FRAC_W];
      u.is_zero = (u.exp == '0);
      u.is_inf  = (u.exp == '1) && (frac == '0);
      u.is_nan  = (u.exp == '1) && (frac != '0);
      u.sig     = u.is_zero ? '0 : {1'b1, frac};
      return u;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// 28-bit leading-zero counter for add/sub normalisation.
// An all-zero input reports 28.
module fp_lzc (
   input  logic [27:0] value,
   output logic [4:0]  count
);

   always_comb begin
      count = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (value[i]) count = 5'(27 - i);
      end
   end

endmodule

// File: rtl/add_sub.sv
// Binary32 adder/subtractor with round-to-nearest-even, flush-to-zero
// on input and output, and a single output register.
module add_sub
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        A_S,
   output logic [31:0] O
);

   fp_unpacked_t     ua;
   fp_unpacked_t     ub;
   logic             swap;
   logic             x_sign;
   logic [EXP_W-1:0] x_exp;
   logic [EXP_W-1:0] y_exp;
   logic [SIG_W-1:0] x_sig;
   logic [SIG_W-1:0] y_sig;
   logic             eff_sub;

   logic [EXP_W-1:0] exp_diff;
   logic [4:0]       shamt;
   logic [EXT_W-1:0] y_ext;
   logic [EXT_W-1:0] y_shift;
   logic             y_lost;
   logic [EXT_W-1:0] y_align;

   logic [27:0]      raw;
   logic [4:0]       lz;
   logic [4:0]       lz_m1;
   logic [EXT_W-1:0] norm;
   logic [9:0]       exp_norm;

   logic [SIG_W-1:0] rsig;
   logic             round_up;
   logic [SIG_W:0]   sum_rnd;
   logic [FRAC_W-1:0] frac_rnd;
   logic [9:0]       exp_rnd;
   logic             underflow;
   logic             overflow;

   logic [31:0]      result;

   assign ua = fp_unpack(A, 1'b0);
   assign ub = fp_unpack(B, A_S);

   // Magnitude order on the raw exponent/fraction bits; ties keep A as X.
   assign swap    = (B[30:0] > A[30:0]);
   assign x_sign  = swap ? ub.sign : ua.sign;
   assign x_exp   = swap ? ub.exp  : ua.exp;
   assign y_exp   = swap ? ua.exp  : ub.exp;
   assign x_sig   = swap ? ub.sig  : ua.sig;
   assign y_sig   = swap ? ua.sig  : ub.sig;
   assign eff_sub = ua.sign ^ ub.sign;

   assign exp_diff = x_exp - y_exp;
   assign shamt    = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
   assign y_ext    = {y_sig, 3'b000};
   assign y_shift  = y_ext >> shamt;
   assign y_lost   = |(y_ext & ~({EXT_W{1'b1}} << shamt));
   assign y_align  = {y_shift[EXT_W-1:1], y_shift[0] | y_lost};

   assign raw = eff_sub ? ({1'b0, x_sig, 3'b000} - {1'b0, y_align})
                        : ({1'b0, x_sig, 3'b000} + {1'b0, y_align});

   fp_lzc u_lzc (
      .value (raw),
      .count (lz)
   );

   assign lz_m1 = lz - 5'd1;

   // Carry-out shifts right once; otherwise the leading one is pulled up
   // to bit 26 (lz_m1 is zero for a plain add without carry).
   always_comb begin
      norm     = '0;
      exp_norm = '0;
      if (raw[27]) begin
         norm     = {raw[27:2], raw[1] | raw[0]};
         exp_norm = {2'b00, x_exp} + 10'd1;
      end else begin
         norm     = raw[EXT_W-1:0] << lz_m1;
         exp_norm = {2'b00, x_exp} - {5'b00000, lz_m1};
      end
   end

   assign rsig     = norm[EXT_W-1:3];
   assign round_up = norm[2] & (norm[1] | norm[0] | rsig[0]);
   assign sum_rnd  = {1'b0, rsig} + {{SIG_W{1'b0}}, round_up};
   assign frac_rnd = sum_rnd[SIG_W] ? sum_rnd[FRAC_W:1] : sum_rnd[FRAC_W-1:0];
   assign exp_rnd  = sum_rnd[SIG_W] ? exp_norm + 10'd1 : exp_norm;

   assign underflow = exp_norm[9] || (exp_norm == 10'd0);
   assign overflow  = (exp_rnd >= 10'(EXP_MAX));

   always_comb begin
      result = '0;
      if (ua.is_nan || ub.is_nan) begin
         result = QNAN;
      end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
         result = QNAN;
      end else if (ua.is_inf) begin
         result = ua.sign ? NEG_INF : POS_INF;
      end else if (ub.is_inf) begin
         result = ub.sign ? NEG_INF : POS_INF;
      end else if (ua.is_zero && ub.is_zero) begin
         result = {ua.sign & ub.sign, 31'd0};
      end else if (ua.is_zero) begin
         result = {ub.sign, B[30:0]};
      end else if (ub.is_zero) begin
         result = {ua.sign, A[30:0]};
      end else if (raw == '0) begin
         result = '0;
      end else if (underflow) begin
         result = {x_sign, 31'd0};
      end else if (overflow) begin
         result = x_sign ? NEG_INF : POS_INF;
      end else begin
         result = {x_sign, exp_rnd[EXP_W-1:0], frac_rnd};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) O <= '0;
      else     O <= result;
   end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: exact-integer reference model,
// per-cycle compare, plus literal vectors that pin the model.
module tb_add_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic        A_S;
   logic [31:0] O;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        chk_en   = 1'b0;
   logic [31:0] model_o;

   add_sub dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .A_S (A_S),
      .O   (O)
   );

   always #5 clk = ~clk;

   task automatic check(input logic [31:0] act, input logic [31:0] want,
                        input string name);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Exact value of the sum as an integer times a power of two, then RNE.
   function automatic logic [31:0] ref_add_sub(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic op);
      logic sa, sb, sbig;
      int ea, eb, ebig, esml, d, ebase, p, e, sh;
      logic [23:0]  mbig, msml;
      logic [127:0] xi, yi, s, keep, rem, half;
      logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      sa = a[31];
      sb = b[31] ^ op;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan) return 32'h7FC00000;
      if (a_inf && b_inf && (sa != sb)) return 32'h7FC00000;
      if (a_inf) return {sa, 8'hFF, 23'd0};
      if (b_inf) return {sb, 8'hFF, 23'd0};
      if (a_zero && b_zero) return {sa & sb, 31'd0};
      if (a_zero) return {sb, b[30:0]};
      if (b_zero) return {sa, a[30:0]};
      if (a[30:0] >= b[30:0]) begin
         sbig = sa; ebig = ea; esml = eb;
         mbig = {1'b1, a[22:0]}; msml = {1'b1, b[22:0]};
      end else begin
         sbig = sb; ebig = eb; esml = ea;
         mbig = {1'b1, b[22:0]}; msml = {1'b1, a[22:0]};
      end
      d = ebig - esml;
      if (d <= 60) begin
         xi = 128'(mbig) << d; yi = 128'(msml); ebase = esml;
      end else begin
         xi = 128'(mbig) << 60; yi = 128'd1; ebase = ebig - 60;
      end
      s = (sa == sb) ? xi + yi : xi - yi;
      if (s == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 128; i++) if (s[i]) p = i;
      e = ebase + p - 23;
      if (e <= 0) return {sbig, 31'd0};
      if (p > 23) begin
         sh   = p - 23;
         keep = s >> sh;
         rem  = s & ((128'd1 << sh) - 128'd1);
         half = 128'd1 << (sh - 1);
         if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
         if (keep == (128'd1 << 24)) begin
            keep = keep >> 1;
            e    = e + 1;
         end
      end else begin
         keep = s << (23 - p);
      end
      if (e >= 255) return {sbig, 8'hFF, 23'd0};
      return {sbig, 8'(e), keep[22:0]};
   endfunction

   always @(posedge clk) model_o <= rst ? 32'h0 : ref_add_sub(A, B, A_S);

   always @(negedge clk) if (chk_en) check(O, model_o, "stream");

   task automatic directed(input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] lit,
                           input string name);
      @(negedge clk);
      A = a; B = b; A_S = s; rst = 1'b0;
      check(ref_add_sub(a, b, s), lit, {"model_", name});
      @(posedge clk);
      #1 check(O, lit, name);
   endtask

   logic [31:0] spec_tab [8] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                                 32'hFF800000, 32'h7FC00001, 32'hFFFFFFFF,
                                 32'h00000123, 32'h3F800000};

   initial begin
      rst = 1'b1;
      A   = 32'hDEADBEEF;
      B   = 32'h12345678;
      A_S = 1'b1;
      @(posedge clk);
      #1 check(O, 32'h0, "reset");
      chk_en = 1'b1;

      directed(32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, "add_1p5_2p5");
      directed(32'hC17CCCCD, 32'hC14CCCCD, 1'b1, 32'hC0400000, "sub_neg");
      directed(32'hC14CCCCD, 32'hC17CCCCD, 1'b1, 32'h40400000, "sub_neg_swap");
      directed(32'h3FCA3D71, 32'hC14CCCCD, 1'b1, 32'h4166147B, "mixed_round");
      directed(32'h41200000, 32'h41200000, 1'b1, 32'h00000000, "cancel");
      directed(32'h80000000, 32'h00000000, 1'b0, 32'h00000000, "neg0_pos0");
      directed(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, "inf_minus_inf");
      directed(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, "inf_plus_one");
      directed(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, "nan_in");
      directed(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, "overflow");
      directed(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, "tie_even_down");
      directed(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, "tie_odd_up");

      @(negedge clk);
      rst = 1'b1; A = 32'h3F800000; B = 32'h3F800000; A_S = 1'b0;
      @(posedge clk);
      #1 check(O, 32'h0, "reset_priority");

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a, b;
         int          cls, t, ea;
         @(negedge clk);
         cls = int'($urandom_range(0, 9));
         a = $urandom;
         b = $urandom;
         if (cls >= 4 && cls <= 6) begin
            ea = int'($urandom_range(1, 254));
            t  = ea + int'($urandom_range(0, 4)) - 2;
            if (t < 1) t = 1;
            if (t > 254) t = 254;
            a = {1'($urandom), 8'(ea), 23'($urandom)};
            b = {1'($urandom), 8'(t),
                 (cls == 6) ? (a[22:0] ^ 23'($urandom_range(0, 15)))
                            : 23'($urandom)};
         end else if (cls == 7) begin
            if ($urandom_range(0, 1) == 0) a = spec_tab[$urandom_range(0, 7)];
            else                           b = spec_tab[$urandom_range(0, 7)];
         end else if (cls == 8) begin
            a = {1'($urandom), 8'($urandom_range(0, 2)), 23'($urandom)};
         end else if (cls == 9) begin
            a = {1'($urandom), 8'($urandom_range(252, 254)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(252, 254)), 23'($urandom)};
         end
         A   = a;
         B   = b;
         A_S = 1'($urandom);
         rst = ($urandom_range(0, 99) == 0);
      end

      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
